cap_current_estimator: RTL

Synchronous fixed-point differentiator, the inverse of the capacitor integrator model. It receives a stream of sampled capacitor voltages and reconstructs the charging current as i[n] = K·(v[n] − v[n−1]) >>> SHIFT. K encodes C/Ts; the default of 25 corresponds to 100 nF sampled every 4 ns. The block sits downstream of the voltage sampler and drives the current-monitor/logging path through valid/ready handshakes on both sides.

---
 rtl/cap_current_estimator_if.sv | 19 +
 rtl/cap_current_estimator.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cap_current_estimator_if.sv
// Handshake bundle for cap_current_estimator: voltage sample in, current result out.
// slave = the estimator, master = the producer/consumer around it.
interface cap_current_estimator_if #(
  parameter int VW = 16,
  parameter int IW = 16
) ();
  logic                 v_valid;
  logic                 v_ready;
  logic signed [VW-1:0] v_data;
  logic                 i_valid;
  logic                 i_ready;
  logic signed [IW-1:0] i_data;
  logic                 i_sat;

  modport slave  (input  v_valid, v_data, i_ready,
                  output v_ready, i_valid, i_data, i_sat);
  modport master (output v_valid, v_data, i_ready,
                  input  v_ready, i_valid, i_data, i_sat);
endinterface

// File: rtl/cap_current_estimator.sv
// cap_current_estimator: fixed-point differentiator i[n] = K*(v[n]-v[n-1]) >>> SHIFT.
// Pipeline: diff register -> product register -> output register (reduced to IW bits).
// Optional macro CAP_DIFF_SAT_EN: saturate the IW reduction instead of wrapping,
// flagging i_sat and counting clipped results in sat_cnt.
module cap_current_estimator #(
  parameter int          VW     = 16,
  parameter int          IW     = 16,
  parameter int          KW     = 16,
  parameter int unsigned K_GAIN = 25,
  parameter int          SHIFT  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  cap_current_estimator_if.slave  bus,
  output logic                    primed,
  output logic [7:0]              sat_cnt
);
  localparam int DW = VW + 1;
  localparam int PW = VW + 1 + KW;
  localparam logic signed [PW-1:0] K_EXT = {{(PW-KW){1'b0}}, KW'(K_GAIN)};

  typedef enum logic {EMPTY, PRIMED} state_t;

  state_t               state_q, state_d;
  logic signed [VW-1:0] prev_q, prev_d;
  logic signed [DW-1:0] diff_q, diff_d;
  logic                 s1_v_q, s1_v_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic                 s2_v_q, s2_v_d;
  logic signed [IW-1:0] i_data_q, i_data_d;
  logic                 i_valid_q, i_valid_d;
  logic                 i_sat_q, i_sat_d;
  logic [7:0]           sat_cnt_q, sat_cnt_d;

  logic                 adv, accept;
  logic signed [PW-1:0] shifted;
  logic signed [IW-1:0] res;
  logic                 clip;
  logic                 unused_hi;

  // Whole pipeline stalls together while a result waits for the consumer.
  assign adv         = !i_valid_q || bus.i_ready;
  assign bus.v_ready = adv && !clr && !rst;
  assign accept      = bus.v_valid && bus.v_ready;

  // Shift the registered product and reduce it to the output width.
  always_comb begin
    shifted   = prod_q >>> SHIFT;
    res       = shifted[IW-1:0];
    clip      = 1'b0;
    unused_hi = 1'b0;
`ifdef CAP_DIFF_SAT_EN
    // Fits in IW bits only if every bit above the IW sign bit copies it.
    if (!((&shifted[PW-1:IW-1]) || !(|shifted[PW-1:IW-1]))) begin
      clip = 1'b1;
      res  = shifted[PW-1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
    end
`else
    unused_hi = ^shifted[PW-1:IW];
`endif
  end

  // Next-state: FSM, pipeline advance, output load, flush on clr.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    diff_d    = diff_q;
    s1_v_d    = s1_v_q;
    prod_d    = prod_q;
    s2_v_d    = s2_v_q;
    i_data_d  = i_data_q;
    i_valid_d = i_valid_q;
    i_sat_d   = i_sat_q;
    sat_cnt_d = sat_cnt_q;
    if (adv) begin
      s1_v_d    = 1'b0;
      s2_v_d    = s1_v_q;
      prod_d    = {{(PW-DW){diff_q[DW-1]}}, diff_q} * K_EXT;
      i_valid_d = s2_v_q;
      if (s2_v_q) begin
        i_data_d = res;
        i_sat_d  = clip;
        if (clip && sat_cnt_q != 8'hFF) sat_cnt_d = sat_cnt_q + 8'd1;
      end
      if (accept) begin
        prev_d = bus.v_data;
        if (state_q == EMPTY) begin
          state_d = PRIMED;
        end else begin
          diff_d = {bus.v_data[VW-1], bus.v_data} - {prev_q[VW-1], prev_q};
          s1_v_d = 1'b1;
        end
      end
    end
    if (clr) begin
      state_d   = EMPTY;
      prev_d    = '0;
      s1_v_d    = 1'b0;
      s2_v_d    = 1'b0;
      i_valid_d = 1'b0;
    end
  end

  // State registers; rst also clears the clip counter and output data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      prev_q    <= '0;
      diff_q    <= '0;
      s1_v_q    <= 1'b0;
      prod_q    <= '0;
      s2_v_q    <= 1'b0;
      i_data_q  <= '0;
      i_valid_q <= 1'b0;
      i_sat_q   <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      diff_q    <= diff_d;
      s1_v_q    <= s1_v_d;
      prod_q    <= prod_d;
      s2_v_q    <= s2_v_d;
      i_data_q  <= i_data_d;
      i_valid_q <= i_valid_d;
      i_sat_q   <= i_sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign bus.i_valid = i_valid_q;
  assign bus.i_data  = i_data_q;
  assign bus.i_sat   = i_sat_q;
  assign primed      = (state_q == PRIMED);
  assign sat_cnt     = sat_cnt_q;
endmodule
